lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute stage: it takes the ALU-computed effective address plus store data and a memory-op code, performs one access on a simple request/response data-memory bus, and returns the lane-aligned, sign- or zero-extended load result (or a store-completion token) to write-back. It is a multi-cycle, single-outstanding-access block with valid/ready handshakes on both sides and a response timeout.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu.sv | 190 +++++++++++++++++++
 tb/tb_lsu.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op-code fields, access sizes,
// FSM state encoding and error codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    localparam int OP_UNS   = 2;
    localparam int OP_STORE = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes/data placement, load
// extraction with sign/zero extension, and the alignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  size_e       size_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] rword_s;

    assign wdata_o = wdata_i << {off_i, 3'b000};
    assign rword_s = rdata_i >> {off_i, 3'b000};

    // Size decode: strobes, misalignment and extended load value
    always_comb begin
        wstrb_o    = 4'b0000;
        misalign_o = 1'b0;
        rdata_o    = rword_s;
        case (size_i)
            SZ_B: begin
                wstrb_o = 4'b0001 << off_i;
                rdata_o = uns_i ? {24'h000000, rword_s[7:0]}
                                : {{24{rword_s[7]}}, rword_s[7:0]};
            end
            SZ_H: begin
                wstrb_o    = 4'b0011 << off_i;
                misalign_o = off_i[0];
                rdata_o    = uns_i ? {16'h0000, rword_s[15:0]}
                                   : {{16{rword_s[15]}}, rword_s[15:0]};
            end
            SZ_W: begin
                wstrb_o    = 4'b1111;
                misalign_o = (off_i != 2'b00);
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding access FSM between execute and a
// request/response data-memory bus, with a response timeout.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    input  logic [3:0]  lsu_op,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_err
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [1:0]  off_q, off_d;
    size_e       size_q, size_d;
    logic        uns_q, uns_d;
    logic        store_q, store_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] out_data_q, out_data_d;
    err_e        out_err_q, out_err_d;

    logic [1:0]  al_off_s;
    size_e       al_size_s;
    logic        al_uns_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_sh_s;
    logic [31:0] rdata_ext_s;
    logic        misalign_s;

    // Aligner decodes the incoming op while idle, the latched op afterwards
    always_comb begin
        if (state_q == ST_IDLE) begin
            al_off_s  = addr[1:0];
            al_size_s = size_e'(lsu_op[1:0]);
            al_uns_s  = lsu_op[OP_UNS];
        end else begin
            al_off_s  = off_q;
            al_size_s = size_q;
            al_uns_s  = uns_q;
        end
    end

    lsu_align u_align (
        .off_i      (al_off_s),
        .size_i     (al_size_s),
        .uns_i      (al_uns_s),
        .wdata_i    (wdata_in),
        .rdata_i    (mem_rsp_rdata),
        .wstrb_o    (wstrb_s),
        .wdata_o    (wdata_sh_s),
        .rdata_o    (rdata_ext_s),
        .misalign_o (misalign_s)
    );

    // Next-state and datapath capture
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        store_d     = store_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = mem_wen_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    off_d      = addr[1:0];
                    size_d     = size_e'(lsu_op[1:0]);
                    uns_d      = lsu_op[OP_UNS];
                    store_d    = lsu_op[OP_STORE];
                    out_data_d = 32'h0000_0000;
                    if (misalign_s) begin
                        state_d   = ST_DONE;
                        out_err_d = ERR_MISALIGN;
                    end else begin
                        state_d     = ST_REQ;
                        out_err_d   = ERR_NONE;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wen_d   = lsu_op[OP_STORE];
                        mem_wdata_d = wdata_sh_s;
                        mem_wstrb_d = lsu_op[OP_STORE] ? wstrb_s : 4'b0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_RESP;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                // A response arriving on the timeout cycle still completes normally
                if (mem_rsp_valid) begin
                    state_d    = ST_DONE;
                    out_err_d  = ERR_NONE;
                    out_data_d = store_q ? 32'h0000_0000 : rdata_ext_s;
                end else if (cnt_q == TMO_LAST) begin
                    state_d    = ST_DONE;
                    out_err_d  = ERR_TIMEOUT;
                    out_data_d = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            off_q       <= 2'b00;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            store_q     <= 1'b0;
            cnt_q       <= 16'd0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
            out_data_q  <= 32'h0000_0000;
            out_err_q   <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            store_q     <= store_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign mem_req_valid = (state_q == ST_REQ);
    assign out_valid     = (state_q == ST_DONE);
    assign mem_addr      = mem_addr_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign out_data      = out_data_q;
    assign out_err       = out_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: transaction-level model predicts bus fields,
// results and cycle timing; one process compares the DUT every cycle.
module tb_lsu;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic [3:0]  lsu_op;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_err;

    int n_vec;
    int n_bad;

    // expected cycle-level view, set by the driver from the model
    logic        exp_idle, exp_req_ok, exp_out_ok;
    logic [31:0] exp_mem_addr, exp_wdata, exp_out_data;
    logic        exp_wen;
    logic [3:0]  exp_wstrb;
    logic [1:0]  exp_out_err;
    logic [31:0] cap_addr, cap_wdata, cap_out;
    logic [3:0]  cap_wstrb;
    logic [1:0]  cap_err;

    lsu #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .addr          (addr),
        .wdata_in      (wdata_in),
        .lsu_op        (lsu_op),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_err       (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_mis(input logic [31:0] a, input logic [3:0] op);
        int sz;
        sz = int'(op[1:0]);
        if (sz == 3) return 1'b1;
        return (int'(a[1:0]) % (1 << sz)) != 0;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [31:0] a, input logic [3:0] op);
        int nb;
        logic [3:0] v;
        if (op[3] == 1'b0) return 4'b0000;
        nb = 1 << int'(op[1:0]);
        v  = 4'((32'd1 << nb) - 32'd1);
        return v << a[1:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] a, input logic [31:0] wd);
        return wd << (8 * int'(a[1:0]));
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a, input logic [3:0] op);
        logic [31:0] w, mask, v;
        int nb;
        w    = rd >> (8 * int'(a[1:0]));
        nb   = 8 << int'(op[1:0]);
        mask = (nb >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
        v    = w & mask;
        if (op[2] == 1'b0 && nb < 32 && v[nb-1] == 1'b1) v = v | ~mask;
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            check("in_ready",  32'(in_ready),      32'(exp_idle));
            check("req_valid", 32'(mem_req_valid), 32'(exp_req_ok));
            check("out_valid", 32'(out_valid),     32'(exp_out_ok));
            if (exp_req_ok && mem_req_valid) begin
                check("mem_addr",  mem_addr,         exp_mem_addr);
                check("mem_wen",   32'(mem_wen),     32'(exp_wen));
                check("mem_wstrb", 32'(mem_wstrb),   32'(exp_wstrb));
                if (exp_wen) check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_out_ok && out_valid) begin
                check("out_data", out_data,      exp_out_data);
                check("out_err",  32'(out_err),  32'(exp_out_err));
            end
        end
    end

    // One access; rsp_delay<0 means no response. Called at a negedge with DUT idle.
    task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] op,
                             input logic [31:0] rd, input int rsp_delay, input int req_stall,
                             input int out_stall, input bit late_rsp);
        int  k_out;
        bit  mis;
        mis          = m_mis(a, op);
        exp_mem_addr = {a[31:2], 2'b00};
        exp_wen      = op[3];
        exp_wstrb    = m_wstrb(a, op);
        exp_wdata    = m_wdata(a, wd);
        if (mis) begin
            exp_out_err  = 2'b01;
            exp_out_data = 32'h0;
        end else if (rsp_delay < 0) begin
            exp_out_err  = 2'b10;
            exp_out_data = 32'h0;
        end else begin
            exp_out_err  = 2'b00;
            exp_out_data = op[3] ? 32'h0 : m_load(rd, a, op);
        end
        in_valid = 1'b1; addr = a; wdata_in = wd; lsu_op = op;
        @(negedge clk);
        in_valid = 1'b0;
        exp_idle = 1'b0;
        if (mis) begin
            exp_out_ok = 1'b1;
        end else begin
            exp_req_ok = 1'b1;
            for (int s = 0; s <= req_stall; s++) begin
                if (s > 0) @(negedge clk);
                mem_req_ready = (s == req_stall);
            end
            cap_addr = mem_addr; cap_wstrb = mem_wstrb; cap_wdata = mem_wdata;
            k_out = (rsp_delay < 0) ? TMO + 1 : rsp_delay + 2;
            for (int k = 1; k <= k_out; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    mem_req_ready = 1'b0;
                    exp_req_ok    = 1'b0;
                end
                mem_rsp_valid = (rsp_delay >= 0) && (k == rsp_delay + 1);
                mem_rsp_rdata = rd;
                if (k == k_out) exp_out_ok = 1'b1;
            end
        end
        out_ready = (out_stall == 0);
        for (int s = 1; s <= out_stall; s++) begin
            @(negedge clk);
            mem_rsp_valid = late_rsp;
            mem_rsp_rdata = 32'hFFFF_FFFF;
            out_ready     = (s == out_stall);
        end
        cap_out = out_data; cap_err = out_err;
        @(negedge clk);
        out_ready     = 1'b0;
        mem_rsp_valid = 1'b0;
        exp_out_ok    = 1'b0;
        exp_idle      = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_bad = 0;
        rst = 1'b1; in_valid = 1'b0; addr = 32'h0; wdata_in = 32'h0; lsu_op = 4'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0; out_ready = 1'b0;
        exp_idle = 1'b1; exp_req_ok = 1'b0; exp_out_ok = 1'b0;
        exp_mem_addr = 32'h0; exp_wdata = 32'h0; exp_out_data = 32'h0;
        exp_wen = 1'b0; exp_wstrb = 4'h0; exp_out_err = 2'b00;

        // model pins against hand-computed values
        check("pin_lb",    m_load(32'h80AB_CDEF, 32'h8000_0003, 4'b0000), 32'hFFFF_FF80);
        check("pin_lhu",   m_load(32'hBEEF_1234, 32'h8000_0002, 4'b0101), 32'h0000_BEEF);
        check("pin_sb_st", 32'(m_wstrb(32'h8000_0001, 4'b1000)), 32'h0000_0002);
        check("pin_sb_wd", m_wdata(32'h8000_0001, 32'h1234_56A5), 32'h3456_A500);
        check("pin_mis",   32'(m_mis(32'h8000_0002, 4'b0010)), 32'h0000_0001);

        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),      32'h1);
        check("rst_req_valid", 32'(mem_req_valid), 32'h0);
        check("rst_wen",       32'(mem_wen),       32'h0);
        check("rst_wstrb",     32'(mem_wstrb),     32'h0);
        check("rst_addr",      mem_addr,           32'h0);
        check("rst_wdata",     mem_wdata,          32'h0);
        check("rst_out_valid", 32'(out_valid),     32'h0);
        check("rst_out_data",  out_data,           32'h0);
        check("rst_out_err",   32'(out_err),       32'h0);
        rst = 1'b0;
        @(negedge clk);

        // lb, best case
        do_access(32'h8000_0003, 32'h0, 4'b0000, 32'h80AB_CDEF, 0, 0, 0, 1'b0);
        check("lb_data",  cap_out,         32'hFFFF_FF80);
        check("lb_addr",  cap_addr,        32'h8000_0000);
        check("lb_wstrb", 32'(cap_wstrb),  32'h0);
        // lhu
        do_access(32'h8000_0002, 32'h0, 4'b0101, 32'hBEEF_1234, 0, 0, 0, 1'b0);
        check("lhu_data", cap_out, 32'h0000_BEEF);
        // sb
        do_access(32'h8000_0001, 32'h1234_56A5, 4'b1000, 32'h5555_5555, 1, 0, 0, 1'b0);
        check("sb_wstrb", 32'(cap_wstrb), 32'h2);
        check("sb_wdata", cap_wdata,      32'h3456_A500);
        check("sb_out",   cap_out,        32'h0);
        check("sb_err",   32'(cap_err),   32'h0);
        // misaligned word
        do_access(32'h8000_0002, 32'h0, 4'b0010, 32'h0, 0, 0, 0, 1'b0);
        check("mis_err", 32'(cap_err), 32'h1);
        // timeout, with late responses while waiting in DONE
        do_access(32'h0000_1000, 32'h0, 4'b0010, 32'hFFFF_FFFF, -1, 0, 2, 1'b1);
        check("tmo_err",  32'(cap_err), 32'h2);
        check("tmo_data", cap_out,       32'h0);
        // stalled request and stalled write-back
        do_access(32'h0000_0020, 32'hDEAD_BEEF, 4'b1010, 32'h0, 1, 3, 2, 1'b0);
        // response on the last cycle before timeout wins
        do_access(32'h0000_0040, 32'h0, 4'b0010, 32'h1234_5678, TMO - 1, 0, 0, 1'b0);
        check("late_ok_data", cap_out,       32'h1234_5678);
        check("late_ok_err",  32'(cap_err),  32'h0);
        // more lane/extension cases
        do_access(32'h0000_0002, 32'h0, 4'b0001, 32'h8001_0000, 0, 1, 1, 1'b0);
        do_access(32'h0000_0001, 32'h0, 4'b0100, 32'h0000_F000, 2, 0, 0, 1'b0);
        check("lbu_data", cap_out, 32'h0000_00F0);
        do_access(32'h0000_0002, 32'h0000_ABCD, 4'b1001, 32'h0, 0, 0, 0, 1'b0);
        check("sh_wstrb", 32'(cap_wstrb), 32'hC);
        check("sh_wdata", cap_wdata,      32'hABCD_0000);
        do_access(32'h0000_0000, 32'h0, 4'b0011, 32'h0, 0, 0, 1, 1'b0);
        do_access(32'h0000_0001, 32'h0, 4'b0001, 32'h0, 0, 0, 0, 1'b0);
        do_access(32'h0000_0002, 32'h0, 4'b0000, 32'h007F_0000, 0, 0, 0, 1'b0);
        check("lb_pos_data", cap_out, 32'h0000_007F);

        // reset while waiting for a response
        in_valid = 1'b1; addr = 32'h0000_0100; lsu_op = 4'b0010; wdata_in = 32'h0;
        exp_mem_addr = 32'h0000_0100; exp_wen = 1'b0; exp_wstrb = 4'b0000;
        @(negedge clk);
        in_valid = 1'b0; exp_idle = 1'b0; exp_req_ok = 1'b1; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; exp_req_ok = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; exp_idle = 1'b1;
        check("rstmid_out_valid", 32'(out_valid),     32'h0);
        check("rstmid_req_valid", 32'(mem_req_valid), 32'h0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("rstmid_drop", 32'(out_valid), 32'h0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
